uart_rx: RTL
============

# uart_rx

Asynchronous serial receiver: the receive end of the team's 8N1 UART link, paired with the existing UART transmitter at the same bit period. It synchronizes the RX line, detects and validates the start bit, and samples each bit at mid-period. It presents the received byte with a sticky ready flag, plus framing-error and overrun status, to the command/host logic that consumes it.

## Interface
- BAUD_DIV, 2604: clocks per bit; must match the transmitter. Legal range is ≥ 16.
- clk  input  1  system clock; every flop is clocked on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- RX  input  1  serial line; asynchronous to clk; idles high.
- clr_rdy  input  1  consumer acknowledge; clears rdy, frm_err and ovr.
- rx_data  output  8  last good byte received.
- rdy  output  1  sticky; a good byte is available.
- frm_err  output  1  sticky; the last frame had a stop bit of 0.
- ovr  output  1  sticky; a good byte arrived while rdy was already high.

## Operation
- **Synchronizer:** RX passes through a 2-flop synchronizer (reset value 1), then a third flop rx_prev (reset value 1).
  - Start edge = rx_s==0 && rx_prev==1.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** on start edge, load baud_cnt = BAUD_DIV/2 − 1 (integer divide), clear bit_cnt, go to START.
  - **START:** decrement baud_cnt. At 0, sample rx_s.
    - If 1: false start; go to IDLE with no flag change.
    - If 0: reload baud_cnt = BAUD_DIV − 1 and go to DATA.
  - **DATA:** decrement baud_cnt. At 0, shift rx_s into shift_reg[7] (right shift, so data arrives LSB first), increment bit_cnt, and reload BAUD_DIV − 1.
    - After the 8th sample (bit_cnt wraps 7→0), go to STOP.
  - **STOP:** decrement baud_cnt. At 0, sample rx_s, then go to IDLE.
    - If 1: rx_data ← shift_reg; rdy ← 1; if rdy was already 1 and clr_rdy is not active in the same cycle, ovr ← 1.
    - If 0: frm_err ← 1; rx_data and rdy are unchanged.
- **Re-arm:** only a new 1→0 transition re-arms IDLE, so a line held low after a framing error (break) does not retrigger.
- **Simultaneous set and clear:** a set event and clr_rdy in the same cycle result in the flag being set. ovr is not set in that case.
- **Widths:** baud_cnt is $clog2(BAUD_DIV) bits and counts down with no wrap. bit_cnt is 3 bits.

## Timing
- **Reset values:** rdy=0, frm_err=0, ovr=0, rx_data=8'h00, state=IDLE, sync flops=1.
- **Reference point:** E is the cycle in which the start edge is seen. The raw RX fall is 2–3 clocks earlier.
- **Sample points:**
  - Start validation at E + BAUD_DIV/2.
  - Data bit i (i = 0..7) at E + BAUD_DIV/2 + (i+1)·BAUD_DIV.
  - Stop bit at E + BAUD_DIV/2 + 9·BAUD_DIV. For the default this is E + 24738.
- **Flag latency:** rdy, rx_data and frm_err become visible in the cycle after the stop sample.
- **Clear latency:** clr_rdy acts in one cycle; flags read 0 in the next cycle.
- **Reset mid-frame:** returns to IDLE immediately with all outputs at their reset values. The rest of the frame is treated as line activity; only a fresh falling edge starts reception.
- **Next frame:** a new start edge is accepted in the cycle after the STOP sample. There is no dead time.

## Structure
- Shared package uart_pkg:
  - localparam BAUD_DIV_DEFAULT = 2604, shared with the transmitter.
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t.
- One sub-module, uart_sync2: generic 2-flop synchronizer with a parameterized reset value, reusable for other asynchronous inputs.
- The FSM and datapath live in a single module. The FSM uses a combinational next-state block with defaults assigned first.

## Test plan
- **Good byte:** drive an 8N1 frame 0xA5 at BAUD_DIV=2604. rdy rises at E+24739 with rx_data=8'hA5, frm_err=0. Pulse clr_rdy; rdy=0 the next cycle.
- **Glitch:** drive RX low for 500 clocks, then high. There is no rdy or frm_err, the FSM is back in IDLE at E+1302, and a following 0x3C frame is received correctly.
- **Framing error:** send 0x5A with a stop bit of 0, and hold the line low for 3 more bit times. frm_err=1, rdy=0, rx_data unchanged. There is no retrigger until RX rises and falls again.
- **Overrun:** send 0x00 then 0xFF back-to-back with no clr_rdy. After the second frame, rx_data=8'hFF, rdy=1, ovr=1. Asserting clr_rdy in the exact cycle of the 0xFF completion gives ovr=0 and rdy=1.
- **Reset mid-frame:** assert rst_n low during bit 4 of 0xC3. All outputs are at reset values, no spurious rdy appears after release, and the next full 0x81 frame is received correctly.
- **Loopback:** connect the transmitter TX to RX and send 256 sequential bytes. Each rx_data matches the transmitted byte, with no frm_err and no ovr when clr_rdy is pulsed after each rdy.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit period and receiver state encoding,
// common to the transmitter and receiver ends of the link.
package uart_pkg;

    localparam int BAUD_DIV_DEFAULT = 2604;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side handshake of the UART receiver: received byte, sticky status
// flags and the acknowledge that clears them.
interface uart_rx_if;

    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr;
    logic       clr_rdy;

    modport master (
        output rx_data,
        output rdy,
        output frm_err,
        output ovr,
        input  clr_rdy
    );

    modport slave (
        input  rx_data,
        input  rdy,
        input  frm_err,
        input  ovr,
        output clr_rdy
    );

endinterface

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for an asynchronous single-bit input; the
// reset value is a parameter so idle-high and idle-low lines both fit.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes RX, validates the start bit at half a bit
// period, samples each bit mid-period and reports the byte with sticky flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      RX,
    uart_rx_if.master bus
);

    localparam int            CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic          rx_s;
    logic          rx_prev_reg;
    logic          start_edge;

    rx_state_t     state_reg,    state_next;
    logic [CW-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]    bit_cnt_reg,  bit_cnt_next;
    logic [7:0]    shift_reg,    shift_next;
    logic [7:0]    data_reg,     data_next;
    logic          rdy_reg,      rdy_next;
    logic          frm_err_reg,  frm_err_next;
    logic          ovr_reg,      ovr_next;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (RX),
        .q     (rx_s)
    );

    // Only a 1->0 transition arms reception, so a held-low line (break) is ignored.
    assign start_edge = !rx_s && rx_prev_reg;

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        data_next     = data_reg;
        rdy_next      = rdy_reg;
        frm_err_next  = frm_err_reg;
        ovr_next      = ovr_reg;

        // Clear first so a set event in the same cycle takes priority.
        if (bus.clr_rdy) begin
            rdy_next     = 1'b0;
            frm_err_next = 1'b0;
            ovr_next     = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    baud_cnt_next = HALF_LOAD;
                    bit_cnt_next  = 3'd0;
                    state_next    = START;
                end
            end
            START: begin
                if (baud_cnt_reg == '0) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        baud_cnt_next = FULL_LOAD;
                        state_next    = DATA;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg - CNT_ONE;
                end
            end
            DATA: begin
                if (baud_cnt_reg == '0) begin
                    shift_next    = {rx_s, shift_reg[7:1]};
                    bit_cnt_next  = bit_cnt_reg + 3'd1;
                    baud_cnt_next = FULL_LOAD;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg - CNT_ONE;
                end
            end
            STOP: begin
                if (baud_cnt_reg == '0) begin
                    state_next = IDLE;
                    if (rx_s) begin
                        data_next = shift_reg;
                        rdy_next  = 1'b1;
                        if (rdy_reg && !bus.clr_rdy) begin
                            ovr_next = 1'b1;
                        end
                    end else begin
                        frm_err_next = 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_reg  <= 1'b1;
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            data_reg     <= 8'h00;
            rdy_reg      <= 1'b0;
            frm_err_reg  <= 1'b0;
            ovr_reg      <= 1'b0;
        end else begin
            rx_prev_reg  <= rx_s;
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            data_reg     <= data_next;
            rdy_reg      <= rdy_next;
            frm_err_reg  <= frm_err_next;
            ovr_reg      <= ovr_next;
        end
    end

    assign bus.rx_data = data_reg;
    assign bus.rdy     = rdy_reg;
    assign bus.frm_err = frm_err_reg;
    assign bus.ovr     = ovr_reg;

endmodule
